// File: rtl/ex_operand_stage_if.sv
// ============================================================================
// Module   : ex_operand_stage_if
// Purpose  : Handshake, forwarding and ALU-operand bundle for the ID/EX stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_operand_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_funct3;
    logic        in_b30;
    logic        in_use_imm;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_operation;
    logic        alu_control;
    logic        alu_lt;
    logic        alu_ltu;
    logic [4:0]  out_rd;

    modport master (
        output flush, in_valid, in_rs1_val, in_rs2_val, in_imm, in_rs1_addr,
               in_rs2_addr, in_rd_addr, in_funct3, in_b30, in_use_imm,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_operation, alu_control,
               alu_lt, alu_ltu, out_rd
    );

    modport slave (
        input  flush, in_valid, in_rs1_val, in_rs2_val, in_imm, in_rs1_addr,
               in_rs2_addr, in_rd_addr, in_funct3, in_b30, in_use_imm,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_operation, alu_control,
               alu_lt, alu_ltu, out_rd
    );
endinterface

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX register feeding the ALU: forwarding, b-select, lt/ltu flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_stage (
    input  wire logic          clk,
    input  wire logic          rst,
    ex_operand_stage_if.slave  bus
);

    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  addr,
        input logic [31:0] rf_val,
        input logic        mem_en,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_data,
        input logic        wb_en,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        logic [31:0] val;
        val = rf_val;
        if (addr != 5'd0 && mem_en && mem_rd == addr)
            val = mem_data;
        else if (addr != 5'd0 && wb_en && wb_rd == addr)
            val = wb_data;
        return val;
    endfunction

    logic        valid_q, valid_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        ctrl_q, ctrl_d;
    logic        lt_q, lt_d, ltu_q, ltu_d;
    logic [4:0]  rd_q, rd_d, rs1_tag_q, rs1_tag_d, rs2_tag_q, rs2_tag_d;
    logic        use_imm_q, use_imm_d;

    logic        w_in_ready, w_capture, w_stall, w_snoop_a, w_snoop_b, w_ctrl;
    logic [31:0] w_a_new, w_b_new, w_snp_a, w_snp_b, w_cmp_a, w_cmp_b;

    assign w_in_ready = !valid_q || bus.out_ready;
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;
    assign w_stall    = valid_q && !bus.out_ready && !bus.flush;

    assign w_a_new = fwd_sel(bus.in_rs1_addr, bus.in_rs1_val,
                             bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data,
                             bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign w_b_new = bus.in_use_imm ? bus.in_imm :
                     fwd_sel(bus.in_rs2_addr, bus.in_rs2_val,
                             bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data,
                             bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
    // Immediates keep bit 30 only for the shift-right group (SRLI/SRAI).
    assign w_ctrl = bus.in_b30 && (!bus.in_use_imm || bus.in_funct3 == 3'b101);

    assign w_snoop_a = w_stall && bus.wb_fwd_en && bus.wb_fwd_rd != 5'd0
                       && bus.wb_fwd_rd == rs1_tag_q;
    assign w_snoop_b = w_stall && bus.wb_fwd_en && bus.wb_fwd_rd != 5'd0
                       && !use_imm_q && bus.wb_fwd_rd == rs2_tag_q;
    assign w_snp_a   = w_snoop_a ? bus.wb_fwd_data : a_q;
    assign w_snp_b   = w_snoop_b ? bus.wb_fwd_data : b_q;

    // Capture and stall are mutually exclusive, so one comparator pair serves both.
    assign w_cmp_a = w_capture ? w_a_new : w_snp_a;
    assign w_cmp_b = w_capture ? w_b_new : w_snp_b;

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        ctrl_d    = ctrl_q;
        lt_d      = lt_q;
        ltu_d     = ltu_q;
        rd_d      = rd_q;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        use_imm_d = use_imm_q;

        if (bus.flush)          valid_d = 1'b0;
        else if (w_capture)     valid_d = 1'b1;
        else if (bus.out_ready) valid_d = 1'b0;

        if (w_capture) begin
            a_d       = w_a_new;
            b_d       = w_b_new;
            op_d      = bus.in_funct3;
            ctrl_d    = w_ctrl;
            rd_d      = bus.in_rd_addr;
            rs1_tag_d = bus.in_rs1_addr;
            rs2_tag_d = bus.in_rs2_addr;
            use_imm_d = bus.in_use_imm;
            lt_d      = $signed(w_cmp_a) < $signed(w_cmp_b);
            ltu_d     = w_cmp_a < w_cmp_b;
        end else if (w_snoop_a || w_snoop_b) begin
            a_d   = w_snp_a;
            b_d   = w_snp_b;
            lt_d  = $signed(w_cmp_a) < $signed(w_cmp_b);
            ltu_d = w_cmp_a < w_cmp_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            op_q      <= 3'd0;
            ctrl_q    <= 1'b0;
            lt_q      <= 1'b0;
            ltu_q     <= 1'b0;
            rd_q      <= 5'd0;
            rs1_tag_q <= 5'd0;
            rs2_tag_q <= 5'd0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            ctrl_q    <= ctrl_d;
            lt_q      <= lt_d;
            ltu_q     <= ltu_d;
            rd_q      <= rd_d;
            rs1_tag_q <= rs1_tag_d;
            rs2_tag_q <= rs2_tag_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.alu_operation = op_q;
    assign bus.alu_control   = ctrl_q;
    assign bus.alu_lt        = lt_q;
    assign bus.alu_ltu       = ltu_q;
    assign bus.out_rd        = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Scoreboard bench for ex_operand_stage with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_operand_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
    } item_t;

    logic clk;
    logic rst;
    ex_operand_stage_if bus ();

    ex_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endfunction

    // Reference forwarding rule: youngest matching non-zero producer wins.
    function automatic logic [31:0] ref_src(logic [4:0] addr, logic [31:0] rf);
        if (addr == 0) return rf;
        if (bus.mem_fwd_en && bus.mem_fwd_rd == addr) return bus.mem_fwd_data;
        if (bus.wb_fwd_en && bus.wb_fwd_rd == addr) return bus.wb_fwd_data;
        return rf;
    endfunction

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
        bus.in_rs1_val = 0; bus.in_rs2_val = 0; bus.in_imm = 0;
        bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
        bus.in_funct3 = 0; bus.in_b30 = 0; bus.in_use_imm = 0;
        bus.mem_fwd_en = 0; bus.mem_fwd_rd = 0; bus.mem_fwd_data = 0;
        bus.wb_fwd_en = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0;
    endtask

    task automatic instr(logic [2:0] f3, logic b30, logic imm_sel, logic [31:0] imm,
                         logic [4:0] r1, logic [31:0] v1, logic [4:0] r2,
                         logic [31:0] v2, logic [4:0] rd);
        bus.in_valid = 1; bus.in_funct3 = f3; bus.in_b30 = b30;
        bus.in_use_imm = imm_sel; bus.in_imm = imm;
        bus.in_rs1_addr = r1; bus.in_rs1_val = v1;
        bus.in_rs2_addr = r2; bus.in_rs2_val = v2; bus.in_rd_addr = rd;
    endtask

    // Advance one clock edge and update the model with what that edge does.
    task automatic step();
        bit    held, cap, stall;
        item_t ni;
        held  = (q.size() != 0);
        cap   = bus.in_valid && (!held || bus.out_ready) && !bus.flush;
        stall = held && !bus.out_ready && !bus.flush;
        ni.a       = ref_src(bus.in_rs1_addr, bus.in_rs1_val);
        ni.b       = bus.in_use_imm ? bus.in_imm : ref_src(bus.in_rs2_addr, bus.in_rs2_val);
        ni.op      = bus.in_funct3;
        ni.ctrl    = bus.in_use_imm ? (bus.in_b30 && bus.in_funct3 == 3'd5) : bus.in_b30;
        ni.rd      = bus.in_rd_addr;
        ni.rs1     = bus.in_rs1_addr;
        ni.rs2     = bus.in_rs2_addr;
        ni.use_imm = bus.in_use_imm;
        @(posedge clk);
        #1;
        if (bus.flush) q.delete();
        else if (cap) q.push_back(ni);
        else if (stall && bus.wb_fwd_en && bus.wb_fwd_rd != 0 && q.size() != 0) begin
            if (q[0].rs1 == bus.wb_fwd_rd) q[0].a = bus.wb_fwd_data;
            if (!q[0].use_imm && q[0].rs2 == bus.wb_fwd_rd) q[0].b = bus.wb_fwd_data;
        end
    endtask

    // Monitor: occupancy/ready every cycle, full entry on every consume.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", {127'd0, bus.out_valid}, {127'd0, q.size() != 0});
            chk("in_ready", {127'd0, bus.in_ready}, {127'd0, (q.size() == 0) || bus.out_ready});
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                item_t e;
                e = q.pop_front();
                chk("entry",
                    {53'd0, bus.alu_a, bus.alu_b, bus.alu_operation, bus.alu_control,
                     bus.out_rd, bus.alu_lt, bus.alu_ltu},
                    {53'd0, e.a, e.b, e.op, e.ctrl, e.rd,
                     $signed(e.a) < $signed(e.b), e.a < e.b});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset mid-stall with a held entry.
        instr(3'd0, 0, 0, 0, 5'd1, 32'd5, 5'd2, 32'd6, 5'd9);
        step();
        idle();
        #2 rst = 1;
        #1;
        chk("rst_outs", {bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_operation,
                         bus.alu_control, bus.alu_lt, bus.alu_ltu, bus.out_rd}, 128'd0);
        chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
        q.delete();
        @(posedge clk);
        #1 rst = 0;

        // ADDI x?, x?, -5 with bit30 set.
        instr(3'd0, 1, 1, 32'hFFFF_FFFB, 5'd1, 32'd7, 5'd2, 32'd0, 5'd4);
        step();
        chk("addi", {bus.alu_b, bus.alu_control, bus.alu_lt, bus.alu_ltu},
            {32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1});
        idle(); bus.out_ready = 1; step();

        // Forward priority: MEM beats WB; x0 never forwards.
        instr(3'd0, 1, 0, 0, 5'd3, 32'd99, 5'd4, 32'd10, 5'd5);
        bus.mem_fwd_en = 1; bus.mem_fwd_rd = 3; bus.mem_fwd_data = 10;
        bus.wb_fwd_en = 1; bus.wb_fwd_rd = 3; bus.wb_fwd_data = 20;
        bus.out_ready = 1;
        step();
        chk("fwd_mem", {bus.alu_a, bus.alu_control, bus.alu_lt}, {32'd10, 1'b1, 1'b0});
        bus.in_rs1_addr = 0; bus.mem_fwd_rd = 0; bus.wb_fwd_rd = 0;
        step();
        chk("fwd_x0", {96'd0, bus.alu_a}, {96'd0, 32'd99});
        idle(); bus.out_ready = 1; step();

        // Stall snoop on rs2.
        instr(3'd2, 0, 0, 0, 5'd6, 32'd3, 5'd5, 32'd1, 5'd7);
        step();
        idle();
        bus.wb_fwd_en = 1; bus.wb_fwd_rd = 5; bus.wb_fwd_data = 32'hFFFF_FFFF;
        step();
        chk("snoop", {bus.alu_b, bus.alu_lt, bus.alu_ltu}, {32'hFFFF_FFFF, 1'b0, 1'b1});
        idle(); bus.out_ready = 1; step();

        // Flush with held entry and a same-cycle request.
        instr(3'd4, 0, 0, 0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
        step();
        instr(3'd6, 0, 0, 0, 5'd1, 32'd8, 5'd2, 32'd9, 5'd10);
        bus.flush = 1;
        step();
        chk("flush_valid", {127'd0, bus.out_valid}, 128'd0);
        bus.flush = 0;
        step();
        chk("post_flush_rd", {123'd0, bus.out_rd}, {123'd0, 5'd10});
        idle(); bus.out_ready = 1; step();

        // Streaming with out_ready pattern 1,0,1,1.
        for (int i = 0; i < 4; i++) begin
            instr(3'(i), 0, 1, 32'(i * 3), 5'd1, 32'(i), 5'd0, 0, 5'(i + 11));
            bus.out_ready = (i != 1);
            step();
            if (i == 1) begin
                bus.in_valid = 0;
                bus.out_ready = 1;
                step();
            end
        end
        idle(); bus.out_ready = 1; step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid     = 1'($urandom_range(0, 3) != 0);
            bus.out_ready    = 1'($urandom_range(0, 9) < 6);
            bus.flush        = 1'($urandom_range(0, 19) == 0);
            bus.in_rs1_val   = $urandom;
            bus.in_rs2_val   = $urandom;
            bus.in_imm       = $urandom;
            bus.in_rs1_addr  = 5'($urandom_range(0, 3));
            bus.in_rs2_addr  = 5'($urandom_range(0, 3));
            bus.in_rd_addr   = 5'($urandom);
            bus.in_funct3    = 3'($urandom);
            bus.in_b30       = 1'($urandom);
            bus.in_use_imm   = 1'($urandom);
            bus.mem_fwd_en   = 1'($urandom);
            bus.mem_fwd_rd   = 5'($urandom_range(0, 3));
            bus.mem_fwd_data = $urandom;
            bus.wb_fwd_en    = 1'($urandom);
            bus.wb_fwd_rd    = 5'($urandom_range(0, 3));
            bus.wb_fwd_data  = $urandom;
            step();
        end

        idle();
        bus.out_ready = 1;
        repeat (3) step();
        chk("drained", {96'd0, 32'(q.size())}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
